// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encoding and accumulator guard width for the SIMD ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_EQ  = 3'b011,
        OP_GT  = 3'b100,
        OP_MAX = 3'b101,
        OP_MIN = 3'b110,
        OP_MAC = 3'b111
    } opcode_t;

    localparam int c_ACC_GUARD = 4;

endpackage
`default_nettype wire

// File: rtl/alu_lane.sv
`default_nettype none
// ============================================================================
// Module      : alu_lane
// Description : One signed SIMD lane with its own MAC accumulator; clamps
//               instead of wrapping when SIMD_ALU_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_lane
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock_in,
    input  logic             reset_n_in,
    input  logic             acc_en_in,
    input  logic             acc_clear_in,
    input  opcode_t          opcode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result_out,
    output logic             overflow_out
);

    localparam int c_ACC_W = 2 * WIDTH + c_ACC_GUARD;

    logic signed [WIDTH-1:0]   w_a;
    logic signed [WIDTH-1:0]   w_b;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [c_ACC_W-1:0]        w_sum_ext;
    logic [c_ACC_W-1:0]        w_diff_ext;
    logic [c_ACC_W-1:0]        w_prod_ext;
    logic [c_ACC_W-1:0]        w_acc_base;
    logic [c_ACC_W-1:0]        w_acc_sum;
    logic [c_ACC_W-1:0]        w_acc_next;
    logic [c_ACC_W-1:0]        r_acc;
    logic [c_ACC_W-1:0]        w_arith;
    logic                      w_arith_op;
    logic                      w_fits;
    logic [WIDTH-1:0]          w_cmp;
    logic [WIDTH-1:0]          w_clamped;

    assign w_a    = $signed(a_in);
    assign w_b    = $signed(b_in);
    assign w_prod = w_a * w_b;

    // Everything is widened to the accumulator width so one range check serves all ops.
    assign w_sum_ext  = {{(c_ACC_W-WIDTH){a_in[WIDTH-1]}}, a_in}
                      + {{(c_ACC_W-WIDTH){b_in[WIDTH-1]}}, b_in};
    assign w_diff_ext = {{(c_ACC_W-WIDTH){a_in[WIDTH-1]}}, a_in}
                      - {{(c_ACC_W-WIDTH){b_in[WIDTH-1]}}, b_in};
    assign w_prod_ext = {{c_ACC_GUARD{w_prod[2*WIDTH-1]}}, w_prod};
    assign w_acc_base = acc_clear_in ? '0 : r_acc;
    assign w_acc_sum  = w_acc_base + w_prod_ext;

`ifdef SIMD_ALU_SATURATE_EN
    localparam logic [WIDTH-1:0] c_MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    logic w_acc_ovf;
    assign w_acc_ovf  = (w_acc_base[c_ACC_W-1] == w_prod_ext[c_ACC_W-1])
                     && (w_acc_sum[c_ACC_W-1] != w_acc_base[c_ACC_W-1]);
    assign w_acc_next = !w_acc_ovf          ? w_acc_sum :
                        w_acc_base[c_ACC_W-1] ? {1'b1, {(c_ACC_W-1){1'b0}}} :
                                                {1'b0, {(c_ACC_W-1){1'b1}}};
`else
    assign w_acc_next = w_acc_sum;
`endif

    always_comb begin
        w_arith    = '0;
        w_arith_op = 1'b0;
        w_cmp      = '0;
        case (opcode_in)
            OP_ADD: begin w_arith = w_sum_ext;  w_arith_op = 1'b1; end
            OP_SUB: begin w_arith = w_diff_ext; w_arith_op = 1'b1; end
            OP_MUL: begin w_arith = w_prod_ext; w_arith_op = 1'b1; end
            OP_MAC: begin w_arith = w_acc_next; w_arith_op = 1'b1; end
            OP_EQ:  w_cmp = {{(WIDTH-1){1'b0}}, (w_a == w_b)};
            OP_GT:  w_cmp = {{(WIDTH-1){1'b0}}, (w_a > w_b)};
            OP_MAX: w_cmp = (w_a > w_b) ? a_in : b_in;
            OP_MIN: w_cmp = (w_a < w_b) ? a_in : b_in;
            default: ;
        endcase
    end

    // A value fits in WIDTH signed bits when all bits from WIDTH-1 upward agree.
    assign w_fits = (&w_arith[c_ACC_W-1:WIDTH-1]) | ~(|w_arith[c_ACC_W-1:WIDTH-1]);

`ifdef SIMD_ALU_SATURATE_EN
    assign w_clamped = w_fits ? w_arith[WIDTH-1:0] :
                       (w_arith[c_ACC_W-1] ? c_MIN_W : c_MAX_W);
`else
    assign w_clamped = w_arith[WIDTH-1:0];
`endif

    assign result_out   = w_arith_op ? w_clamped : w_cmp;
    assign overflow_out = w_arith_op & ~w_fits;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_acc <= '0;
        end else if (acc_en_in) begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/simd_alu.sv
`default_nettype none
// ============================================================================
// Module      : simd_alu
// Description : Two-stage valid/ready SIMD ALU over LANES signed lanes.
//               Define SIMD_ALU_SATURATE_EN for clamping arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   in_valid_in,
    output logic                   in_ready_out,
    input  logic [2:0]             opcode_in,
    input  logic                   acc_clear_in,
    input  logic [LANES*WIDTH-1:0] operand_a_in,
    input  logic [LANES*WIDTH-1:0] operand_b_in,
    output logic                   out_valid_out,
    input  logic                   out_ready_in,
    output logic [LANES*WIDTH-1:0] result_out,
    output logic [LANES-1:0]       overflow_out
);

    logic                   r_s1_valid;
    opcode_t                r_s1_op;
    logic                   r_s1_clear;
    logic [LANES*WIDTH-1:0] r_s1_a;
    logic [LANES*WIDTH-1:0] r_s1_b;
    logic                   r_out_valid;
    logic [LANES*WIDTH-1:0] r_result;
    logic [LANES-1:0]       r_overflow;

    logic                   w_s2_ready;
    logic                   w_s1_move;
    logic                   w_acc_en;
    logic [LANES*WIDTH-1:0] w_lane_res;
    logic [LANES-1:0]       w_lane_ovf;

    assign w_s2_ready    = !r_out_valid || out_ready_in;
    assign w_s1_move     = r_s1_valid && w_s2_ready;
    assign in_ready_out  = !r_s1_valid || w_s2_ready;
    // Accumulators step only on the S1->S2 move, so a stalled MAC cannot count twice.
    assign w_acc_en      = w_s1_move && (r_s1_op == OP_MAC);

    assign out_valid_out = r_out_valid;
    assign result_out    = r_result;
    assign overflow_out  = r_overflow;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            alu_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clock_in     (clock_in),
                .reset_n_in   (reset_n_in),
                .acc_en_in    (w_acc_en),
                .acc_clear_in (r_s1_clear),
                .opcode_in    (r_s1_op),
                .a_in         (r_s1_a[gi*WIDTH +: WIDTH]),
                .b_in         (r_s1_b[gi*WIDTH +: WIDTH]),
                .result_out   (w_lane_res[gi*WIDTH +: WIDTH]),
                .overflow_out (w_lane_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_clear <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (in_ready_out) begin
            r_s1_valid <= in_valid_in;
            if (in_valid_in) begin
                r_s1_op    <= opcode_t'(opcode_in);
                r_s1_clear <= acc_clear_in;
                r_s1_a     <= operand_a_in;
                r_s1_b     <= operand_b_in;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_lane_res;
                r_overflow <= w_lane_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_alu
// Description : Directed self-checking bench for simd_alu (WIDTH=8, LANES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_alu;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
`ifdef SIMD_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                   clock_in = 1'b0;
    logic                   reset_n_in;
    logic                   in_valid_in;
    logic                   in_ready_out;
    logic [2:0]             opcode_in;
    logic                   acc_clear_in;
    logic [LANES*WIDTH-1:0] operand_a_in;
    logic [LANES*WIDTH-1:0] operand_b_in;
    logic                   out_valid_out;
    logic                   out_ready_in;
    logic [LANES*WIDTH-1:0] result_out;
    logic [LANES-1:0]       overflow_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    simd_alu #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clock_in      (clock_in),
        .reset_n_in    (reset_n_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .opcode_in     (opcode_in),
        .acc_clear_in  (acc_clear_in),
        .operand_a_in  (operand_a_in),
        .operand_b_in  (operand_b_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .result_out    (result_out),
        .overflow_out  (overflow_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        pk = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: verifies 2-cycle latency and the delivered result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic clr,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_ovf);
        @(negedge clock_in);
        out_ready_in = 1'b1;
        #1;
        check({tag, ".rdy"}, in_ready_out, 1);
        in_valid_in  = 1'b1;
        opcode_in    = op;
        acc_clear_in = clr;
        operand_a_in = a;
        operand_b_in = b;
        @(negedge clock_in);
        in_valid_in  = 1'b0;
        acc_clear_in = 1'b0;
        check({tag, ".lat1"}, out_valid_out, 0);
        @(negedge clock_in);
        check({tag, ".vld"}, out_valid_out, 1);
        check({tag, ".res"}, result_out, exp_res);
        check({tag, ".ovf"}, overflow_out, exp_ovf);
    endtask

    task automatic run_stream();
        int sent = 0;
        int recv = 0;
        bit saw_block = 1'b0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            @(negedge clock_in);
            out_ready_in = !(c >= 3 && c <= 6);
            #1;
            if (out_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("stream.spurious", out_valid_out, 0);
                end else if (out_ready_in) begin
                    check($sformatf("stream.res%0d", recv), result_out, exp_q.pop_front());
                    recv++;
                end else begin
                    check("stream.hold", result_out, exp_q[0]);
                end
            end
            if (!in_ready_out) saw_block = 1'b1;
            if (sent < 10) begin
                in_valid_in  = 1'b1;
                opcode_in    = OP_ADD;
                acc_clear_in = 1'b1;
                operand_a_in = pk(sent, sent + 1, -sent, 2);
                operand_b_in = pk(1, 1, 1, 1);
                if (in_ready_out) begin
                    exp_q.push_back(pk(sent + 1, sent + 2, 1 - sent, 3));
                    sent++;
                end
            end else begin
                in_valid_in = 1'b0;
            end
        end
        in_valid_in = 1'b0;
        check("stream.count", recv, 10);
        check("stream.blocked", saw_block, 1);
        @(negedge clock_in);
        check("stream.drained", out_valid_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_in   = 1'b0;
        in_valid_in  = 1'b0;
        opcode_in    = 3'd0;
        acc_clear_in = 1'b0;
        operand_a_in = '0;
        operand_b_in = '0;
        out_ready_in = 1'b0;
        #12;
        check("rst.out_valid", out_valid_out, 0);
        check("rst.in_ready", in_ready_out, 1);
        check("rst.result", result_out, 0);
        check("rst.overflow", overflow_out, 0);
        @(negedge clock_in);
        reset_n_in = 1'b1;

        run_op("add", OP_ADD, 1'b0, pk(100, -5, 0, 127), pk(27, 5, 0, 1),
               pk(127, 0, 0, SAT ? 127 : -128), 4'b1000);
        run_op("sub", OP_SUB, 1'b0, pk(-128, 10, -100, 50), pk(1, 20, 100, -100),
               pk(SAT ? -128 : 127, -10, SAT ? -128 : 56, SAT ? 127 : -106), 4'b1101);
        run_op("mul", OP_MUL, 1'b0, pk(3, -4, 16, -128), pk(5, 6, 8, -1),
               pk(15, -24, SAT ? 127 : -128, SAT ? 127 : -128), 4'b1100);
        run_op("gt",  OP_GT,  1'b0, pk(-1, 5, -128, 7), pk(1, 5, 127, -3), pk(0, 0, 0, 1), 4'b0000);
        run_op("max", OP_MAX, 1'b0, pk(-1, 5, -128, 7), pk(1, 5, 127, -3), pk(1, 5, 127, 7), 4'b0000);
        run_op("min", OP_MIN, 1'b0, pk(-1, 5, -128, 7), pk(1, 5, 127, -3), pk(-1, 5, -128, -3), 4'b0000);
        run_op("eq",  OP_EQ,  1'b0, pk(-128, 5, -128, 7), pk(-128, 5, 127, -3), pk(1, 1, 0, 0), 4'b0000);

        run_op("mac1", OP_MAC, 1'b1, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(6, 6, 6, 6), 4'b0000);
        run_op("mac2", OP_MAC, 1'b0, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(12, 12, 12, 12), 4'b0000);
        run_op("mac3", OP_MAC, 1'b0, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(18, 18, 18, 18), 4'b0000);
        run_op("mac4", OP_MAC, 1'b1, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(6, 6, 6, 6), 4'b0000);
        run_op("addclr", OP_ADD, 1'b1, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(5, 5, 5, 5), 4'b0000);
        run_op("mac5", OP_MAC, 1'b0, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(12, 12, 12, 12), 4'b0000);
        run_op("macovf", OP_MAC, 1'b1, pk(127, -128, 2, 0), pk(127, 127, 3, 0),
               pk(SAT ? 127 : 1, -128, 6, 0), 4'b0011);

        run_stream();

        // Two operations in flight, then an asynchronous reset mid-cycle.
        @(negedge clock_in);
        out_ready_in = 1'b0;
        in_valid_in  = 1'b1;
        opcode_in    = OP_ADD;
        operand_a_in = pk(1, 1, 1, 1);
        operand_b_in = pk(1, 1, 1, 1);
        @(negedge clock_in);
        @(negedge clock_in);
        in_valid_in = 1'b0;
        check("flight.vld", out_valid_out, 1);
        #1 reset_n_in = 1'b0;
        #1;
        check("arst.out_valid", out_valid_out, 0);
        check("arst.in_ready", in_ready_out, 1);
        check("arst.result", result_out, 0);
        @(negedge clock_in);
        reset_n_in   = 1'b1;
        out_ready_in = 1'b1;
        @(negedge clock_in);
        check("post_rst.vld0", out_valid_out, 0);
        @(negedge clock_in);
        check("post_rst.vld1", out_valid_out, 0);
        run_op("mac_rst", OP_MAC, 1'b0, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(6, 6, 6, 6), 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simd_alu.md
SIMD_ALU -- requirements
Module: simd_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed lane operand and result width in bits (legal range 4..32).
REQ-002 SHALL have parameter LANES, default 4: number of parallel lanes (legal range 1..16).
REQ-003 SHALL have port clock_in, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid_in, input, 1 bit: the operation presented on the input bus is valid.
REQ-006 SHALL have port in_ready_out, output, 1 bit: the block can accept an operation this cycle.
REQ-007 SHALL have port opcode_in, input, 3 bits: the operation, taken from the alu_pkg opcode enum.
REQ-008 SHALL have port acc_clear_in, input, 1 bit: zero the lane accumulators before a MAC (only meaningful with MAC).
REQ-009 SHALL have port operand_a_in, input, LANES*WIDTH bits: packed signed operand A; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port operand_b_in, input, LANES*WIDTH bits: packed signed operand B, same lane layout as A.
REQ-011 SHALL have port out_valid_out, output, 1 bit: result_out is valid.
REQ-012 SHALL have port out_ready_in, input, 1 bit: the consumer accepts the result this cycle.
REQ-013 SHALL have port result_out, output, LANES*WIDTH bits: packed signed lane results.
REQ-014 SHALL have port overflow_out, output, LANES bits: per-lane overflow flag, qualified by out_valid_out.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid_in and in_ready_out are both high; output transfer SHALL occur where out_valid_out and out_ready_in are both high.
REQ-016 The block SHALL be a 2-stage pipeline: S1 registers the operands and opcode, S2 registers the result; latency from input transfer to out_valid_out high SHALL be exactly 2 cycles when there is no stall.
REQ-017 Sustained throughput SHALL be 1 operation per cycle while out_ready_in is held high.
REQ-018 A stage SHALL advance when it is empty or when the next stage advances this cycle; in_ready_out = !s1_valid || s1_advance, generated combinationally with no dependence on in_valid_in.
REQ-019 While out_valid_out is high and out_ready_in is low, result_out and overflow_out SHALL be held stable and no operation SHALL be lost or duplicated.
REQ-020 Opcodes SHALL be: 000 ADD; 001 SUB; 010 MUL; 011 EQ; 100 GT; 101 MAX; 110 MIN; 111 MAC.
REQ-021 ADD, SUB and MUL SHALL wrap to WIDTH bits (MUL keeps the low WIDTH bits of the 2*WIDTH product); the lane's overflow bit SHALL be set when the true result falls outside the signed WIDTH range.
REQ-022 EQ and GT SHALL return 1 or 0 in the lane as a signed comparison; MAX and MIN SHALL return the signed maximum or minimum; overflow SHALL be 0 for all four.
REQ-023 MAC SHALL compute acc_i = (acc_clear_in ? 0 : acc_i) + a_i*b_i at full 2*WIDTH+4 bit precision; the result SHALL be acc_i truncated to WIDTH bits, and overflow SHALL be set when acc_i is outside the signed WIDTH range.
REQ-024 The accumulators SHALL update only when a MAC moves from S1 to S2; a stalled MAC SHALL NOT update them twice.
REQ-025 acc_clear_in SHALL be ignored for all non-MAC opcodes, and non-MAC opcodes SHALL leave the accumulators unchanged.
REQ-026 An input transfer and an output transfer in the same cycle SHALL both complete, keeping full throughput.

Reset
REQ-027 While reset_n_in is low: s1_valid, out_valid_out, result_out, overflow_out and all accumulators SHALL be 0, and in_ready_out SHALL be 1.
REQ-028 Assertion of reset_n_in mid-operation SHALL discard all in-flight operations immediately; no transfer SHALL occur on the first rising edge after reset deassertion unless in_valid_in is high.

Configuration
REQ-029 With SIMD_ALU_SATURATE_EN defined, ADD, SUB, MUL and MAC results SHALL clamp to the signed WIDTH range (the overflow bit still reports clamping), and the accumulators SHALL saturate at 2*WIDTH+4 bits.
REQ-030 Without SIMD_ALU_SATURATE_EN, results SHALL wrap as specified in REQ-021 and REQ-023.

Structure
REQ-031 alu_pkg SHALL hold the opcode enum (ADD..MAC) and the accumulator guard-bit constant (4).
REQ-032 Per-lane arithmetic SHALL be a sub-module alu_lane, instantiated LANES times by a generate loop; alu_lane SHALL contain its own accumulator and saturation logic, and the handshake SHALL remain in simd_alu.

Verification (WIDTH=8, LANES=4)
REQ-033 ADD with A=lanes{100,-5,0,127} and B={27,5,0,1} SHALL give {127,0,0,-128} with overflow=4'b1000, valid 2 cycles after the transfer.
REQ-034 The same ADD with SIMD_ALU_SATURATE_EN defined SHALL give lane3=127 with overflow bit 3 set.
REQ-035 MAC 3 times with a=2, b=3 (first with acc_clear_in=1) SHALL give results 6, 12, 18; a following MAC with acc_clear_in=1 SHALL give 6.
REQ-036 A back-to-back stream of 10 operations with out_ready_in held low for cycles 3..6 SHALL deliver all 10 results in order, the held result SHALL stay stable, and in_ready_out SHALL fall once both stages are full.
REQ-037 reset_n_in pulsed low while 2 operations are in flight SHALL drop out_valid_out to 0 asynchronously; a MAC after reset SHALL start from acc=0.
REQ-038 GT with a=-1, b=1 SHALL give 0; MAX on the same operands SHALL give 1; MIN SHALL give -1; EQ with a=-128, b=-128 SHALL give 1.
